// File: rtl/seq_1011_detector.sv
// Moore FSM that flags each received 1-0-1-1 serial pattern with a one-cycle pulse on z.
// Define SEQ_1011_OVERLAP_EN to let the trailing "1" of a match start the next pattern.
module seq_1011_detector (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Codes 5-7 fall into the default arm and recover to S0 on the next edge.
    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = x ? S1    : S0;
            S1:      state_next = x ? S1    : S10;
            S10:     state_next = x ? S101  : S0;
            S101:    state_next = x ? S1011 : S10;
`ifdef SEQ_1011_OVERLAP_EN
            S1011:   state_next = x ? S1    : S10;
`else
            S1011:   state_next = x ? S1    : S0;
`endif
            default: state_next = S0;
        endcase
    end

    // z is decoded purely from the state register, so x has no path to it.
    always_comb begin
        z = 1'b0;
        if (state == S1011) begin
            z = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_1011_detector.sv
// Directed bench for seq_1011_detector: drives x/rst on the falling edge and checks z
// (and the state register during reset) 1 time unit after each rising edge.
module tb_seq_1011_detector;

    logic clk;
    logic rst;
    logic x;
    logic z;

    int total;
    int bad;

    seq_1011_detector dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic xv, input logic rv);
        @(negedge clk);
        x   = xv;
        rst = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic exp_z);
        total++;
        assert (z === exp_z)
        else begin
            bad++;
            $error("[TB] FAIL %s: z=%b expected %b", tag, z, exp_z);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp_state);
        logic [2:0] observed;
        observed = dut.state;
        total++;
        assert (observed === exp_state)
        else begin
            bad++;
            $error("[TB] FAIL %s: state=%0d expected %0d", tag, observed, exp_state);
        end
    endtask

    task automatic step(input logic xv, input logic rv, input logic exp_z, input string tag);
        apply_stimulus(xv, rv);
        check_output(tag, exp_z);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        x     = 1'b0;
        rst   = 1'b1;

        $display("[TB] reset hold with x toggling");
        step(1'b1, 1'b1, 1'b0, "rst_edge1_z");
        check_state("rst_edge1_state", 3'd0);
        step(1'b0, 1'b1, 1'b0, "rst_edge2_z");
        check_state("rst_edge2_state", 3'd0);

        $display("[TB] first pattern after reset");
        step(1'b1, 1'b0, 1'b0, "post_rst_1");
        step(1'b0, 1'b0, 1'b0, "post_rst_0");
        step(1'b1, 1'b0, 1'b0, "post_rst_01");
        step(1'b1, 1'b0, 1'b1, "post_rst_detect");
        step(1'b1, 1'b0, 1'b0, "post_rst_single_cycle");

        $display("[TB] basic detect 0,1,0,1,1");
        step(1'b1, 1'b1, 1'b0, "basic_rst");
        step(1'b0, 1'b0, 1'b0, "basic_s1");
        step(1'b1, 1'b0, 1'b0, "basic_s2");
        step(1'b0, 1'b0, 1'b0, "basic_s3");
        step(1'b1, 1'b0, 1'b0, "basic_s4");
        step(1'b1, 1'b0, 1'b1, "basic_s5_detect");
        step(1'b0, 1'b0, 1'b0, "basic_after");

        $display("[TB] overlap stream 1,0,1,1,0,1,1");
        step(1'b0, 1'b1, 1'b0, "ovl_rst");
        step(1'b1, 1'b0, 1'b0, "ovl_s1");
        step(1'b0, 1'b0, 1'b0, "ovl_s2");
        step(1'b1, 1'b0, 1'b0, "ovl_s3");
        step(1'b1, 1'b0, 1'b1, "ovl_s4_detect");
        step(1'b0, 1'b0, 1'b0, "ovl_s5");
        step(1'b1, 1'b0, 1'b0, "ovl_s6");
`ifdef SEQ_1011_OVERLAP_EN
        step(1'b1, 1'b0, 1'b1, "ovl_s7_second_detect");
`else
        step(1'b1, 1'b0, 1'b0, "ovl_s7_no_second");
`endif

        $display("[TB] near-miss stream 1,0,0,1,1,1,0,1,0,1,1");
        step(1'b0, 1'b1, 1'b0, "near_rst");
        step(1'b1, 1'b0, 1'b0, "near_s1");
        step(1'b0, 1'b0, 1'b0, "near_s2");
        step(1'b0, 1'b0, 1'b0, "near_s3");
        step(1'b1, 1'b0, 1'b0, "near_s4_1001");
        step(1'b1, 1'b0, 1'b0, "near_s5");
        step(1'b1, 1'b0, 1'b0, "near_s6_111");
        step(1'b0, 1'b0, 1'b0, "near_s7");
        step(1'b1, 1'b0, 1'b0, "near_s8");
        step(1'b0, 1'b0, 1'b0, "near_s9");
        step(1'b1, 1'b0, 1'b0, "near_s10");
        step(1'b1, 1'b0, 1'b1, "near_s11_detect");

        $display("[TB] reset mid-sequence");
        step(1'b0, 1'b1, 1'b0, "mid_rst_init");
        step(1'b1, 1'b0, 1'b0, "mid_s1");
        step(1'b0, 1'b0, 1'b0, "mid_s2");
        step(1'b1, 1'b0, 1'b0, "mid_s3");
        step(1'b1, 1'b1, 1'b0, "mid_rst_pulse");
        check_state("mid_rst_state", 3'd0);
        step(1'b1, 1'b0, 1'b0, "mid_after_rst_1");
        step(1'b0, 1'b0, 1'b0, "mid_after_rst_0");
        step(1'b1, 1'b0, 1'b0, "mid_after_rst_01");
        step(1'b1, 1'b0, 1'b1, "mid_after_rst_detect");
        step(1'b0, 1'b0, 1'b0, "mid_after_pulse");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
